// File: rtl/bit_stream_serializer_if.sv
// rtl/bit_stream_serializer_if.sv - word-in / bit-out handshake bundle for bit_stream_serializer
interface bit_stream_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             stream_out;
  logic             stream_valid;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  stream_out,
    input  stream_valid
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output stream_out,
    output stream_valid
  );
endinterface

// File: rtl/bit_stream_serializer.sv
// rtl/bit_stream_serializer.sv - MSB-first word serializer with one-word holding register; SER_PARITY_EN adds an even-parity slot
module bit_stream_serializer #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  bit_stream_serializer_if.slave s,
  output logic                   busy,
  output logic                   underrun,
  input  logic                   underrun_clr
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR} state_t;
`else
  typedef enum logic {S_IDLE, S_SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] hr_q, hr_d;
  logic             hr_full_q, hr_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             data_ready_q, data_ready_d;
  logic             stream_out_q, stream_out_d;
  logic             stream_valid_q, stream_valid_d;
  logic             busy_q, busy_d;
  logic             underrun_q, underrun_d;
`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif

  logic             accept;
  logic             word_end;
  logic             load_sr;
  logic [WIDTH-1:0] load_word;

  always_comb begin
    accept         = s.data_valid & data_ready_q;
    word_end       = 1'b0;
    load_sr        = 1'b0;
    load_word      = '0;
    state_d        = state_q;
    sr_d           = sr_q;
    hr_d           = hr_q;
    hr_full_d      = hr_full_q;
    cnt_d          = cnt_q;
    stream_out_d   = 1'b0;
    stream_valid_d = 1'b0;
    underrun_d     = underrun_q & ~underrun_clr;
`ifdef SER_PARITY_EN
    par_d          = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          load_sr   = 1'b1;
          load_word = s.data_in;
        end
      end
      S_SHIFT: begin
        if (cnt_q != CW'(WIDTH)) begin
          stream_out_d   = sr_q[WIDTH-1];
          stream_valid_d = 1'b1;
          sr_d           = sr_q << 1;
          cnt_d          = cnt_q + CW'(1);
          if (accept) begin
            hr_d      = s.data_in;
            hr_full_d = 1'b1;
          end
        end else begin
`ifdef SER_PARITY_EN
          state_d        = S_PAR;
          stream_out_d   = par_q;
          stream_valid_d = 1'b1;
          if (accept) begin
            hr_d      = s.data_in;
            hr_full_d = 1'b1;
          end
`else
          word_end = 1'b1;
`endif
        end
      end
`ifdef SER_PARITY_EN
      S_PAR: word_end = 1'b1;
`endif
      default: state_d = S_IDLE;
    endcase

    // Final slot just left the output: chain the next word with no gap, or go idle.
    if (word_end) begin
      if (hr_full_q) begin
        load_sr   = 1'b1;
        load_word = hr_q;
        hr_full_d = 1'b0;
        if (accept) begin
          hr_d      = s.data_in;
          hr_full_d = 1'b1;
        end
      end else if (accept) begin
        load_sr   = 1'b1;
        load_word = s.data_in;
      end else begin
        state_d    = S_IDLE;
        sr_d       = '0;
        cnt_d      = '0;
        underrun_d = 1'b1;
      end
    end

    if (load_sr) begin
      state_d        = S_SHIFT;
      stream_out_d   = load_word[WIDTH-1];
      stream_valid_d = 1'b1;
      sr_d           = load_word << 1;
      cnt_d          = CW'(1);
`ifdef SER_PARITY_EN
      par_d          = ^load_word;
`endif
    end

    data_ready_d = ~hr_full_d;
    busy_d       = (state_d != S_IDLE) | hr_full_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      sr_q           <= '0;
      hr_q           <= '0;
      hr_full_q      <= 1'b0;
      cnt_q          <= '0;
      data_ready_q   <= 1'b0;
      stream_out_q   <= 1'b0;
      stream_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      underrun_q     <= 1'b0;
`ifdef SER_PARITY_EN
      par_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      sr_q           <= sr_d;
      hr_q           <= hr_d;
      hr_full_q      <= hr_full_d;
      cnt_q          <= cnt_d;
      data_ready_q   <= data_ready_d;
      stream_out_q   <= stream_out_d;
      stream_valid_q <= stream_valid_d;
      busy_q         <= busy_d;
      underrun_q     <= underrun_d;
`ifdef SER_PARITY_EN
      par_q          <= par_d;
`endif
    end
  end

  assign s.data_ready   = data_ready_q;
  assign s.stream_out   = stream_out_q;
  assign s.stream_valid = stream_valid_q;
  assign busy           = busy_q;
  assign underrun       = underrun_q;

endmodule
